// File: rtl/ysyx_23060184_axil_sram.sv
// ysyx_23060184_axil_sram: AXI4-Lite slave word-array memory, independent read/write FSMs; define SRAM_RAND_DELAY_EN for LFSR-jittered latency
module ysyx_23060184_axil_sram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(32'h8000_0000),
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int OFF = $clog2(BW);
  localparam int IW = $clog2(DEPTH);
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  blk_q;
  logic [4:0]            rnd;
  logic [4:0]            rd_lat;
  logic [4:0]            wr_lat;

  r_state_e              r_q, r_d;
  logic [4:0]            rcnt_q, rcnt_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rd_load;
  logic [ADDR_WIDTH-1:0] rd_addr;

  w_state_e              w_q, w_d;
  logic [4:0]            wcnt_q, wcnt_d;
  logic                  aw_got_q, aw_got_d;
  logic                  w_got_q, w_got_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BW-1:0]         wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  wr_do;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wa;
  logic [DATA_WIDTH-1:0] wd;
  logic [BW-1:0]         ws;

  function automatic logic [1:0] decode(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return a[OFF-1:0] != '0 ? SLVERR :
           (a < BASE_ADDR || (off >> OFF) >= ADDR_WIDTH'(DEPTH)) ? DECERR : OKAY;
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IW'((a - BASE_ADDR) >> OFF);
  endfunction

`ifdef SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q;
  // Free-running x^8+x^6+x^5+x^4+1 LFSR that jitters each latency load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
  assign rnd = {2'b00, lfsr_q[2:0]};
`else
  assign rnd = '0;
`endif

  assign rd_lat  = 5'(RD_LAT) + rnd;
  assign wr_lat  = 5'(WR_LAT) + rnd;

  assign arready = r_q == R_IDLE && !blk_q;
  assign rvalid  = r_q == R_RESP;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign awready = w_q == W_IDLE && !aw_got_q && !blk_q;
  assign wready  = w_q == W_IDLE && !w_got_q && !blk_q;
  assign bvalid  = w_q == W_RESP;
  assign bresp   = bresp_q;

  assign wa    = aw_got_q ? awaddr_q : awaddr;
  assign wd    = w_got_q ? wdata_q : wdata;
  assign ws    = w_got_q ? wstrb_q : wstrb;
  assign wr_en = wr_do && bresp_d == OKAY;

  // Read channel next-state; response is sampled from the array on R_RESP entry
  always_comb begin
    r_d     = r_q;
    rcnt_d  = rcnt_q;
    raddr_d = raddr_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    rd_load = 1'b0;
    rd_addr = raddr_q;
    case (r_q)
      R_IDLE: if (arvalid && arready) begin
        raddr_d = araddr;
        rd_addr = araddr;
        rcnt_d  = rd_lat;
        r_d     = rd_lat == '0 ? R_RESP : R_WAIT;
        rd_load = rd_lat == '0;
      end
      R_WAIT: begin
        rcnt_d = rcnt_q - 5'd1;
        if (rcnt_q == 5'd1) begin
          r_d     = R_RESP;
          rd_load = 1'b1;
        end
      end
      R_RESP: if (rready) r_d = R_IDLE;
      default: r_d = R_IDLE;
    endcase
    if (rd_load) begin
      rresp_d = decode(rd_addr);
      rdata_d = rresp_d == OKAY ? mem[word_idx(rd_addr)] : '0;
    end
  end

  // Write channel next-state; AW and W are captured independently in W_IDLE
  always_comb begin
    w_d      = w_q;
    wcnt_d   = wcnt_q;
    aw_got_d = aw_got_q;
    w_got_d  = w_got_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bresp_d  = bresp_q;
    wr_do    = 1'b0;
    case (w_q)
      W_IDLE: begin
        if (awvalid && awready) begin
          awaddr_d = awaddr;
          aw_got_d = 1'b1;
        end
        if (wvalid && wready) begin
          wdata_d = wdata;
          wstrb_d = wstrb;
          w_got_d = 1'b1;
        end
        if (aw_got_d && w_got_d) begin
          wcnt_d = wr_lat;
          w_d    = wr_lat == '0 ? W_RESP : W_WAIT;
          wr_do  = wr_lat == '0;
        end
      end
      W_WAIT: begin
        wcnt_d = wcnt_q - 5'd1;
        if (wcnt_q == 5'd1) begin
          w_d   = W_RESP;
          wr_do = 1'b1;
        end
      end
      W_RESP: if (bready) begin
        w_d      = W_IDLE;
        aw_got_d = 1'b0;
        w_got_d  = 1'b0;
      end
      default: w_d = W_IDLE;
    endcase
    if (wr_do) bresp_d = decode(wa);
  end

  // State and response registers; reset aborts any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_q    <= 1'b1;
      r_q      <= R_IDLE;
      rcnt_q   <= '0;
      raddr_q  <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      w_q      <= W_IDLE;
      wcnt_q   <= '0;
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= '0;
    end else begin
      blk_q    <= 1'b0;
      r_q      <= r_d;
      rcnt_q   <= rcnt_d;
      raddr_q  <= raddr_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      w_q      <= w_d;
      wcnt_q   <= wcnt_d;
      aw_got_q <= aw_got_d;
      w_got_q  <= w_got_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
    end
  end

  // Byte-lane array update on W_RESP entry; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int i = 0; i < BW; i++)
        if (ws[i]) mem[word_idx(wa)][8*i +: 8] <= wd[8*i +: 8];
  end
endmodule

// File: tb/tb_ysyx_23060184_axil_sram.sv
// tb_ysyx_23060184_axil_sram: directed vector table plus randomized traffic against a byte-level memory model
module tb_ysyx_23060184_axil_sram;
  localparam int RDL = 1;
  localparam int WRL = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  int total = 0;
  int passed = 0;

  logic [7:0] mem_m [logic [31:0]];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdat;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  ysyx_23060184_axil_sram #(.RD_LAT(RDL), .WR_LAT(WRL)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    if (a % 4 != 0) return 2'b10;
    if (a < 32'h8000_0000 || (a - 32'h8000_0000) / 4 >= 4096) return 2'b11;
    return 2'b00;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (exp_resp(a) == 2'b00)
      for (int i = 0; i < 4; i++)
        if (s[i]) mem_m[a + 32'(i)] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (exp_resp(a) != 2'b00) return 32'h0;
    return {mem_m[a + 3], mem_m[a + 2], mem_m[a + 1], mem_m[a]};
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly,
                          output logic [1:0] resp, output int blat, output bit early, output bit stuck);
    bit aw_done, w_done, fa, fw;
    int c;
    aw_done = 0; w_done = 0; c = 0; early = 0; stuck = 0;
    awaddr = a; wdata = d; wstrb = s; bready = 1'b1;
    while (!(aw_done && w_done) && c < 50) begin
      awvalid = !aw_done && c >= aw_dly;
      wvalid  = !w_done && c >= w_dly;
      if (bvalid) early = 1;
      if (w_done && !aw_done && wready) stuck = 1;
      fa = awvalid && awready;
      fw = wvalid && wready;
      tick();
      aw_done |= fa;
      w_done  |= fw;
      c++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    blat = 0;
    while (!bvalid && blat < 50) begin
      tick();
      blat++;
    end
    resp = bresp;
    tick();
  endtask

  task automatic do_read(input logic [31:0] a, input int hold,
                         output logic [31:0] data, output logic [1:0] resp, output int lat,
                         output bit dropped, output bit stable, output bit back);
    int c;
    araddr = a; arvalid = 1'b1; rready = 1'b0; c = 0;
    while (!arready && c < 50) begin
      tick();
      c++;
    end
    tick();
    arvalid = 1'b0;
    dropped = !arready;
    lat = 1;
    while (!rvalid && lat < 50) begin
      tick();
      lat++;
    end
    data = rdata; resp = rresp; stable = 1;
    repeat (hold) begin
      tick();
      if (!rvalid || rdata !== data || rresp !== resp) stable = 0;
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    back = !rvalid && arready;
  endtask

  initial begin
    logic [31:0] d, a, e;
    logic [3:0]  s;
    logic [1:0]  resp;
    int          lat;
    bit          b0, b1, b2;

    vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
    vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h8000_0010, 32'h1122_3344, 4'h5, 2'b00, 32'h0};
    vecs[3]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 2'b00, 32'hDE22_BE44};
    vecs[4]  = '{1'b0, 32'h8000_0012, 32'h0,         4'h0, 2'b10, 32'h0};
    vecs[5]  = '{1'b1, 32'h8000_3FFC, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0};
    vecs[6]  = '{1'b1, 32'h7FFF_FFFC, 32'h1234_5678, 4'hF, 2'b11, 32'h0};
    vecs[7]  = '{1'b0, 32'h8000_3FFC, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D};
    vecs[8]  = '{1'b1, 32'h8000_4010, 32'h9999_9999, 4'hF, 2'b11, 32'h0};
    vecs[9]  = '{1'b0, 32'h8000_4000, 32'h0,         4'h0, 2'b11, 32'h0};
    vecs[10] = '{1'b1, 32'h8000_0010, 32'hAABB_CCDD, 4'h0, 2'b00, 32'h0};
    vecs[11] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 2'b00, 32'hDE22_BE44};
    vecs[12] = '{1'b1, 32'h8000_0013, 32'h7777_7777, 4'hF, 2'b10, 32'h0};
    vecs[13] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 2'b00, 32'hDE22_BE44};

    #3 rst = 1'b1;
    repeat (3) begin
      tick();
      chk("reset outputs", {arready, rvalid, awready, wready, bvalid, rresp, bresp, rdata[22:0]}, 32'h0);
      chk("reset rdata", rdata, 32'h0);
    end
    rst = 1'b0;
    chk("ready blocked at release", 32'({arready, awready, wready}), 32'h0);
    tick();
    chk("ready after release", 32'({arready, awready, wready}), 32'h7);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, resp, lat, b0, b1);
        chk($sformatf("vec%0d bresp", i), 32'(resp), 32'(vecs[i].resp));
        chk($sformatf("vec%0d b latency", i), 32'(lat), 32'(WRL));
      end else begin
        do_read(vecs[i].addr, 0, d, resp, lat, b0, b1, b2);
        chk($sformatf("vec%0d rresp", i), 32'(resp), 32'(vecs[i].resp));
        chk($sformatf("vec%0d rdata", i), d, vecs[i].rdat);
        chk($sformatf("vec%0d r latency", i), 32'(lat), 32'(RDL + 1));
        chk($sformatf("vec%0d arready drop", i), 32'(b0), 32'h1);
        chk($sformatf("vec%0d r release", i), 32'(b2), 32'h1);
      end
    end

    do_write(32'h8000_0020, 32'h55AA_1234, 4'hF, 3, 0, resp, lat, b0, b1);
    chk("w-before-aw bresp", 32'(resp), 32'h0);
    chk("w-before-aw early bvalid", 32'(b0), 32'h0);
    chk("w-before-aw wready held", 32'(b1), 32'h0);
    do_read(32'h8000_0020, 5, d, resp, lat, b0, b1, b2);
    chk("w-before-aw readback", d, 32'h55AA_1234);
    chk("backpressure stable", 32'(b1), 32'h1);
    chk("backpressure release", 32'(b2), 32'h1);

    araddr = 32'h8000_0010;
    arvalid = 1'b1;
    for (int c = 0; c < 50 && !arready; c++) tick();
    tick();
    arvalid = 1'b0;
    rst = 1'b1;
    #1;
    chk("reset mid-read outputs", 32'({rvalid, arready}), 32'h0);
    tick();
    chk("reset mid-read rvalid", 32'(rvalid), 32'h0);
    rst = 1'b0;
    tick();
    do_read(32'h8000_0010, 0, d, resp, lat, b0, b1, b2);
    chk("after reset readback", d, 32'hDE22_BE44);
    chk("after reset rresp", 32'(resp), 32'h0);

    for (int k = 0; k < 8; k++) begin
      a = 32'h8000_0000 + 32'(4 * k);
      d = $urandom;
      model_write(a, d, 4'hF);
      do_write(a, d, 4'hF, 0, 0, resp, lat, b0, b1);
      chk("pool init bresp", 32'(resp), 32'h0);
    end
    for (int n = 0; n < 80; n++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      a = 32'h8000_0000 + 32'(4 * $urandom_range(0, 7));
      if (kind == 0) a = a + 32'($urandom_range(1, 3));
      if (kind == 1) a = ($urandom_range(0, 1) == 0) ? 32'h8000_4000 + 32'(4 * $urandom_range(0, 7)) : 32'h7FFF_FFF0;
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        s = 4'($urandom);
        do_write(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), resp, lat, b0, b1);
        chk($sformatf("rand%0d bresp", n), 32'(resp), 32'(exp_resp(a)));
        chk($sformatf("rand%0d b latency", n), 32'(lat), 32'(WRL));
        model_write(a, d, s);
      end else begin
        e = model_read(a);
        do_read(a, int'($urandom_range(0, 2)), d, resp, lat, b0, b1, b2);
        chk($sformatf("rand%0d rresp", n), 32'(resp), 32'(exp_resp(a)));
        chk($sformatf("rand%0d rdata", n), d, e);
        chk($sformatf("rand%0d r stable", n), 32'(b1), 32'h1);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
